// File: rtl/ram_rf_pkg.sv
// Shared definitions for the ram_rf register-file RAM.
// Holds the clear-sequencer state encoding and the address-width helper.
package ram_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clr_state_e;

   // Ceiling log2; DEPTH is at least 2, so the result is never 0.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/ram_rf_if.sv
// Port bundle for ram_rf: write port, read port, clear request and status.
// Handshake: wr_en/rd_en/clr_req are sampled on posedge; rd_valid is a one-cycle strobe, busy blocks all requests.
interface ram_rf_if import ram_pkg::*; #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) ();
   localparam int ADDR_W = clog2(DEPTH);

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [WIDTH-1:0]  wr_data;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [WIDTH-1:0]  rd_data;
   logic              rd_valid;
   logic              clr_req;
   logic              busy;
   clr_state_e        clr_state;

   modport master (
      output wr_en, wr_addr, wr_data, rd_en, rd_addr, clr_req,
      input  rd_data, rd_valid, busy, clr_state
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_en, rd_addr, clr_req,
      output rd_data, rd_valid, busy, clr_state
   );
endinterface

// File: rtl/ram_rf_clr_seq.sv
// Whole-array clear sequencer: IDLE/CLEAR FSM plus a sweep counter.
// Busy is high for exactly DEPTH cycles; the counter stops at DEPTH-1.
module ram_clr_seq import ram_pkg::*; #(
   parameter  int DEPTH  = 16,
   localparam int ADDR_W = clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr_req,
   output logic              busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr,
   output clr_state_e        state_o
);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   clr_state_e        state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic              busy_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (clr_req) begin
                  state_q <= ST_CLEAR;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            ST_CLEAR: begin
               if (cnt_q == LAST) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + ADDR_W'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy     = busy_q;
   assign clr_we   = (state_q == ST_CLEAR);
   assign clr_addr = cnt_q;
   assign state_o  = state_q;

endmodule

// File: rtl/ram_rf.sv
// Parametrised register-file RAM with registered read, write-through on collision
// and a sequenced whole-array clear.
module ram_rf import ram_pkg::*; #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input logic     clk,
   input logic     reset,
   ram_rf_if.slave bus
);
   localparam int ADDR_W = clog2(DEPTH);
   // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [WIDTH-1:0]  rd_data_q, rd_data_d, rd_word;
   logic              rd_valid_q;
   logic              rd_acc, wr_acc;
   logic              busy, clr_we;
   logic [ADDR_W-1:0] clr_addr;

   ram_clr_seq #(.DEPTH(DEPTH)) u_clr_seq (
      .clk      (clk),
      .reset    (reset),
      .clr_req  (bus.clr_req),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr),
      .state_o  (bus.clr_state)
   );

   always_comb begin
      rd_acc = bus.rd_en && !busy;
      // A clear request accepted on this edge wins over a user write.
      wr_acc = bus.wr_en && !busy && !bus.clr_req && ({1'b0, bus.wr_addr} < DEPTH_W);
      rd_word = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (bus.rd_addr == ADDR_W'(i)) rd_word = mem_q[i];
      end
      rd_data_d = rd_data_q;
      if (rd_acc) begin
         if (wr_acc && (bus.wr_addr == bus.rd_addr)) rd_data_d = bus.wr_data;
         else                                        rd_data_d = rd_word;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (clr_we && (clr_addr == ADDR_W'(i)))    mem_q[i] <= '0;
            else if (wr_acc && (bus.wr_addr == ADDR_W'(i))) mem_q[i] <= bus.wr_data;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_acc;
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.busy     = busy;

endmodule

// File: tb/tb_ram_rf.sv
// Self-checking bench for ram_rf: behavioural model with per-cycle compare plus
// directed literal checks, and a second DEPTH=10 instance for out-of-range addresses.
module tb_ram_rf;
   import ram_pkg::*;

   localparam int W  = 8;
   localparam int D  = 16;
   localparam int D2 = 10;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ram_rf_if #(.WIDTH(W), .DEPTH(D))  u_if  ();
   ram_rf_if #(.WIDTH(W), .DEPTH(D2)) u_if2 ();

   ram_rf #(.WIDTH(W), .DEPTH(D))  dut  (.clk(clk), .reset(rst_n), .bus(u_if));
   ram_rf #(.WIDTH(W), .DEPTH(D2)) dut2 (.clk(clk), .reset(rst_n), .bus(u_if2));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [W-1:0] m_mem [D];
   int           clr_left;
   logic         m_valid;
   logic [W-1:0] m_last, m_d;
   logic [W-1:0] exp_q [$];
   bit           m_idle, m_rd_ok, m_wr_ok;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < D; i++) m_mem[i] = '0;
         clr_left = 0;
         m_valid  = 1'b0;
         m_last   = '0;
         exp_q.delete();
      end else begin
         m_idle  = (clr_left == 0);
         m_rd_ok = u_if.rd_en && m_idle;
         m_wr_ok = u_if.wr_en && m_idle && !u_if.clr_req && (int'(u_if.wr_addr) < D);
         if (!m_idle) begin
            m_mem[D - clr_left] = '0;
            clr_left--;
         end
         m_valid = m_rd_ok;
         if (m_rd_ok) begin
            if (int'(u_if.rd_addr) >= D)                              m_d = '0;
            else if (m_wr_ok && (u_if.wr_addr == u_if.rd_addr))       m_d = u_if.wr_data;
            else                                                       m_d = m_mem[u_if.rd_addr];
            exp_q.push_back(m_d);
            m_last = m_d;
         end
         if (m_wr_ok) m_mem[u_if.wr_addr] = u_if.wr_data;
         if (m_idle && u_if.clr_req) clr_left = D;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         chk("busy", u_if.busy, clr_left > 0);
         chk("rd_valid", u_if.rd_valid, m_valid);
         if (m_valid) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL rd_data: got %0h but no expected read queued", u_if.rd_data);
            end else begin
               chk("rd_data", u_if.rd_data, exp_q.pop_front());
            end
         end else begin
            chk("rd_hold", u_if.rd_data, m_last);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle_in();
      u_if.wr_en = 0; u_if.wr_addr = '0; u_if.wr_data = '0;
      u_if.rd_en = 0; u_if.rd_addr = '0; u_if.clr_req = 0;
      u_if2.wr_en = 0; u_if2.wr_addr = '0; u_if2.wr_data = '0;
      u_if2.rd_en = 0; u_if2.rd_addr = '0; u_if2.clr_req = 0;
   endtask

   task automatic wr(input int a, input logic [W-1:0] d);
      u_if.wr_en = 1; u_if.wr_addr = 4'(a); u_if.wr_data = d;
      @(negedge clk);
      u_if.wr_en = 0;
   endtask

   task automatic rd_lit(input int a, input logic [W-1:0] exp, input string name);
      u_if.rd_en = 1; u_if.rd_addr = 4'(a);
      @(negedge clk);
      u_if.rd_en = 0;
      chk({name, "_valid"}, u_if.rd_valid, 1'b1);
      chk(name, u_if.rd_data, exp);
   endtask

   // Consecutive reads; counts cycles with rd_valid high and rd_data zero.
   task automatic rd_burst(input int lo, input int hi, output int zcnt);
      zcnt = 0;
      for (int a = lo; a <= hi; a++) begin
         u_if.rd_en = 1; u_if.rd_addr = 4'(a);
         @(negedge clk);
         if (u_if.rd_valid && (u_if.rd_data == '0)) zcnt++;
      end
      u_if.rd_en = 0;
   endtask

   task automatic wr2(input int a, input logic [W-1:0] d);
      u_if2.wr_en = 1; u_if2.wr_addr = 4'(a); u_if2.wr_data = d;
      @(negedge clk);
      u_if2.wr_en = 0;
   endtask

   task automatic rd2_lit(input int a, input logic [W-1:0] exp, input string name);
      u_if2.rd_en = 1; u_if2.rd_addr = 4'(a);
      @(negedge clk);
      u_if2.rd_en = 0;
      chk({name, "_valid"}, u_if2.rd_valid, 1'b1);
      chk(name, u_if2.rd_data, exp);
   endtask

   // ---------------- directed sequence ----------------
   int zc, bc;

   initial begin
      idle_in();
      #23 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_rd_data", u_if.rd_data, 8'h00);
      chk("rst_rd_valid", u_if.rd_valid, 1'b0);
      chk("rst_busy", u_if.busy, 1'b0);
      chk("rst_state", u_if.clr_state, ST_IDLE);

      // 1: all words read zero, valid continuous over 16 back-to-back reads
      rd_burst(0, 15, zc);
      chk("t1_zero_valid_cycles", zc, 16);
      @(negedge clk);

      // 2: basic write then read
      wr(3, 8'hA5);
      wr(15, 8'h3C);
      rd_lit(3, 8'hA5, "t2_rd3");
      rd_lit(15, 8'h3C, "t2_rd15");

      // 3: write-through on collision
      wr(5, 8'h11);
      u_if.wr_en = 1; u_if.wr_addr = 4'd5; u_if.wr_data = 8'h77;
      u_if.rd_en = 1; u_if.rd_addr = 4'd5;
      @(negedge clk);
      u_if.wr_en = 0; u_if.rd_en = 0;
      chk("t3_bypass", u_if.rd_data, 8'h77);
      rd_lit(5, 8'h77, "t3_reread");

      // 4: fill, clear, user write during sweep is dropped
      for (int a = 0; a < D; a++) wr(a, 8'hFF);
      rd_lit(7, 8'hFF, "t4_prefill");
      u_if.clr_req = 1;
      @(negedge clk);
      u_if.clr_req = 0;
      bc = 0;
      for (int k = 0; k < 40; k++) begin
         if (u_if.busy) bc++;
         if (k == 3) begin
            u_if.wr_en = 1; u_if.wr_addr = 4'd2; u_if.wr_data = 8'h12;
            u_if.rd_en = 1; u_if.rd_addr = 4'd7;
         end
         if (k == 4) begin
            u_if.wr_en = 0; u_if.rd_en = 0;
         end
         if (!u_if.busy) break;
         @(negedge clk);
      end
      u_if.wr_en = 0; u_if.rd_en = 0;
      chk("t4_busy_cycles", bc, 16);
      chk("t4_state_idle", u_if.clr_state, ST_IDLE);
      rd_lit(2, 8'h00, "t4_rd2");
      rd_burst(0, 15, zc);
      chk("t4_all_zero", zc, 16);

      // 5: clear collides with write/read, then reset aborts the sweep
      for (int a = 10; a < D; a++) wr(a, 8'h5A);
      wr(1, 8'h66);
      u_if.clr_req = 1;
      u_if.wr_en = 1; u_if.wr_addr = 4'd1; u_if.wr_data = 8'h99;
      u_if.rd_en = 1; u_if.rd_addr = 4'd1;
      @(negedge clk);
      idle_in();
      chk("t5_preclear_rd", u_if.rd_data, 8'h66);
      chk("t5_busy_on", u_if.busy, 1'b1);
      repeat (6) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_abort_busy", u_if.busy, 1'b0);
      chk("t5_abort_rd_data", u_if.rd_data, 8'h00);
      chk("t5_abort_rd_valid", u_if.rd_valid, 1'b0);
      chk("t5_abort_state", u_if.clr_state, ST_IDLE);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      rd_burst(10, 15, zc);
      chk("t5_unswept_zero", zc, 6);
      rd_lit(1, 8'h00, "t5_rd1");

      // 6: DEPTH=10 instance, out-of-range write dropped and read returns 0
      wr2(9, 8'h44);
      wr2(12, 8'h9A);
      rd2_lit(9, 8'h44, "t6_rd9_before");
      rd2_lit(12, 8'h00, "t6_rd12");
      rd2_lit(9, 8'h44, "t6_rd9_after");
      rd2_lit(2, 8'h00, "t6_rd2_no_alias");

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
      $fatal(1);
   end

endmodule
